// File: rtl/brief_line_window.sv
// brief_line_window: receiving end of the 1-bit line-delay path feeding the
// BRIEF window logic. For every incoming raster pixel it emits a vertical
// column of Pra_Rows bits (current row plus the same column of the previous
// Pra_Rows-1 rows) together with the pixel's raster coordinates.
//
// Stream semantics: i_en qualifies i_data for exactly one cycle; there is no
// backpressure. Each accepted pixel produces one output cycle with o_valid=1
// exactly one clock later. Outputs o_col/o_x/o_y hold while o_valid=0.
module brief_line_window #(
   parameter int Pra_Width  = 1920,
   parameter int Pra_Height = 1080,
   parameter int Pra_Rows   = 5
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_en,
   input  logic                i_data,
   output logic                o_valid,
   output logic [Pra_Rows-1:0] o_col,
   output logic [10:0]         o_x,
   output logic [10:0]         o_y,
   output logic                o_window_ok,
   output logic                o_frame_end
);

   localparam int          AW     = (Pra_Width > 1) ? $clog2(Pra_Width) : 1;
   localparam logic [10:0] X_LAST = 11'(Pra_Width - 1);
   localparam logic [10:0] Y_LAST = 11'(Pra_Height - 1);
   localparam logic [10:0] WOK_Y  = 11'(Pra_Rows - 1);

   // Raster position of the pixel presented on i_data this cycle
   logic [10:0]         x;
   logic [10:0]         y;
   logic [AW-1:0]       addr;
   logic                pix_en;

   // tap[0] is the live pixel; tap[k] is line memory k-1 read at addr
   logic [Pra_Rows-1:0] tap;
   logic [Pra_Rows-1:0] col_next;

   assign addr   = x[AW-1:0];
   assign pix_en = i_en & ~i_rst;
   assign tap[0] = i_data;

   // Line memory cascade: memory k-1 delays the column by k lines. Each
   // memory reads the old bit at addr and overwrites it with the bit that
   // the previous stage held, so the whole column shifts down one line.
   for (genvar g = 1; g < Pra_Rows; g++) begin : g_line
      logic mem [0:Pra_Width-1];

      assign tap[g] = mem[addr];

      // Read-before-write shift of this column by one line (no reset)
      always_ff @(posedge i_clk) begin
         if (pix_en) begin
            mem[addr] <= tap[g-1];
         end
      end
   end

   // Older taps are masked until enough rows of the current frame exist,
   // hiding stale memory after reset or at frame start
   always_comb begin
      col_next    = '0;
      col_next[0] = tap[0];
      for (int k = 1; k < Pra_Rows; k++) begin
         col_next[k] = (y >= 11'(k)) ? tap[k] : 1'b0;
      end
   end

   // Raster column/row counters, advancing once per accepted pixel
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         x <= '0;
         y <= '0;
      end else if (i_en) begin
         if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? 11'd0 : y + 11'd1;
         end else begin
            x <= x + 11'd1;
         end
      end
   end

   // Output register stage aligning pixel, coordinates and memory read data
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_valid     <= 1'b0;
         o_col       <= '0;
         o_x         <= '0;
         o_y         <= '0;
         o_window_ok <= 1'b0;
         o_frame_end <= 1'b0;
      end else begin
         o_valid     <= i_en;
         o_frame_end <= i_en & (x == X_LAST) & (y == Y_LAST);
         o_window_ok <= i_en & (y >= WOK_Y);
         if (i_en) begin
            o_col <= col_next;
            o_x   <= x;
            o_y   <= y;
         end
      end
   end

endmodule

// File: tb/tb_brief_line_window.sv
// Bench for brief_line_window: a small 8x6x3 instance exercised with
// continuous, gapped, row-tagged and mid-frame-reset streams, plus a full
// 1920x1080x5 instance with a single injected pixel.
module tb_brief_line_window;

   localparam int W1 = 8;
   localparam int H1 = 6;
   localparam int R1 = 3;
   localparam int W2 = 1920;
   localparam int H2 = 1080;
   localparam int R2 = 5;
   localparam int E1 = 22 + R1 + 2;
   localparam int E2 = 22 + R2 + 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst1 = 1'b1, en1 = 1'b0, d1 = 1'b0;
   logic          v1, wok1, fe1;
   logic [R1-1:0] col1;
   logic [10:0]   ox1, oy1;

   logic          rst2 = 1'b1, en2 = 1'b0, d2 = 1'b0;
   logic          v2, wok2, fe2;
   logic [R2-1:0] col2;
   logic [10:0]   ox2, oy2;

   brief_line_window #(.Pra_Width(W1), .Pra_Height(H1), .Pra_Rows(R1)) dut1 (
      .i_clk(clk), .i_rst(rst1), .i_en(en1), .i_data(d1),
      .o_valid(v1), .o_col(col1), .o_x(ox1), .o_y(oy1),
      .o_window_ok(wok1), .o_frame_end(fe1)
   );

   brief_line_window #(.Pra_Width(W2), .Pra_Height(H2), .Pra_Rows(R2)) dut2 (
      .i_clk(clk), .i_rst(rst2), .i_en(en2), .i_data(d2),
      .o_valid(v2), .o_col(col2), .o_x(ox2), .o_y(oy2),
      .o_window_ok(wok2), .o_frame_end(fe2)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errs   = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- scoreboard / model state ----------------
   logic [E1-1:0] exp_q1[$];
   logic [E1-1:0] cont_log[$];
   logic [E2-1:0] exp_q2[$];

   int mx1 = 0, my1 = 0;
   int mx2 = 0, my2 = 0;
   bit hist1 [0:H1-1][0:W1-1];
   int exp_fend = 0;
   int fend_cnt = 0;
   int log_mode = 0;

   // ---------------- driver tasks ----------------
   task automatic drive1(input bit en, input bit d);
      logic [R1-1:0] col;
      logic          wk, fe;
      @(posedge clk); #1;
      rst1 = 1'b0;
      en1  = en;
      d1   = d;
      if (en) begin
         col = '0;
         for (int k = 0; k < R1; k++) begin
            if (my1 >= k) col[k] = (k == 0) ? d : hist1[my1-k][mx1];
         end
         hist1[my1][mx1] = d;
         wk = (my1 >= R1 - 1);
         fe = (mx1 == W1 - 1) && (my1 == H1 - 1);
         if (fe) exp_fend++;
         exp_q1.push_back({11'(mx1), 11'(my1), col, wk, fe});
         if (mx1 == W1 - 1) begin
            mx1 = 0;
            my1 = (my1 == H1 - 1) ? 0 : my1 + 1;
         end else begin
            mx1++;
         end
      end
   endtask

   task automatic reset1(input bit en, input bit d);
      @(posedge clk); #1;
      rst1 = 1'b1;
      en1  = en;
      d1   = d;
      mx1  = 0;
      my1  = 0;
   endtask

   task automatic drive2(input bit en, input bit d);
      logic [R2-1:0] col;
      logic          wk, fe;
      @(posedge clk); #1;
      rst2 = 1'b0;
      en2  = en;
      d2   = d;
      if (en) begin
         for (int k = 0; k < R2; k++) begin
            col[k] = (mx2 == 100) && (my2 == 10 + k);
         end
         wk = (my2 >= R2 - 1);
         fe = (mx2 == W2 - 1) && (my2 == H2 - 1);
         exp_q2.push_back({11'(mx2), 11'(my2), col, wk, fe});
         if (mx2 == W2 - 1) begin
            mx2 = 0;
            my2 = (my2 == H2 - 1) ? 0 : my2 + 1;
         end else begin
            mx2++;
         end
      end
   endtask

   // ---------------- monitors ----------------
   logic          s_rst1 = 1'b1, s_en1 = 1'b0;
   logic          s_rst2 = 1'b1, s_en2 = 1'b0;
   logic [E1-1:0] last1 = '0, got1, e1;
   logic [E2-1:0] last2 = '0, got2, e2;

   always @(posedge clk) begin
      s_rst1 <= rst1;
      s_en1  <= en1 & ~rst1;
      s_rst2 <= rst2;
      s_en2  <= en2 & ~rst2;
   end

   always @(negedge clk) begin
      got1 = {ox1, oy1, col1, wok1, fe1};
      if (fe1) fend_cnt++;
      if (s_rst1) begin
         check_val("reset_out1", {v1, got1}, '0);
         last1 = '0;
      end else if (s_en1) begin
         check_val("valid1", v1, 1);
         check_val("sb_level1", exp_q1.size() > 0, 1);
         if (exp_q1.size() > 0) begin
            e1 = exp_q1.pop_front();
            check_val("out1", got1, e1);
            last1 = e1;
            if (log_mode == 1) begin
               cont_log.push_back(e1);
            end else if (log_mode == 2) begin
               check_val("gap_len", cont_log.size() > 0, 1);
               if (cont_log.size() > 0) check_val("gap_seq", got1, cont_log.pop_front());
            end
         end
      end else begin
         check_val("idle1", {v1, got1}, {1'b0, last1[E1-1:2], 2'b00});
      end
   end

   always @(negedge clk) begin
      got2 = {ox2, oy2, col2, wok2, fe2};
      if (s_rst2) begin
         check_val("reset_out2", {v2, got2}, '0);
         last2 = '0;
      end else if (s_en2) begin
         check_val("valid2", v2, 1);
         check_val("sb_level2", exp_q2.size() > 0, 1);
         if (exp_q2.size() > 0) begin
            e2 = exp_q2.pop_front();
            check_val("out2", got2, e2);
            last2 = e2;
         end
      end else begin
         check_val("idle2", {v2, got2}, {1'b0, last2[E2-1:2], 2'b00});
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bit en, d;
      int n;

      repeat (3) @(posedge clk);

      // Continuous stream, pixel = (x+y)&1, one full frame; expected values logged
      log_mode = 1;
      for (int i = 0; i < W1 * H1; i++) drive1(1'b1, 1'((mx1 + my1) & 1));
      repeat (3) drive1(1'b0, 1'b0);
      log_mode = 0;

      // Same frame with ~40% strobe duty must give the same output sequence
      reset1(1'b0, 1'b0);
      drive1(1'b0, 1'b0);
      log_mode = 2;
      n = 0;
      while (n < W1 * H1) begin
         en = ($urandom_range(0, 99) < 40);
         d  = 1'((mx1 + my1) & 1);
         drive1(en, d);
         if (en) n++;
      end
      repeat (3) drive1(1'b0, 1'b0);
      log_mode = 0;
      check_val("gap_done", cont_log.size(), 0);

      // Row-tagged stream over two frames: even rows all-1, odd rows all-0
      reset1(1'b0, 1'b0);
      for (int i = 0; i < 2 * W1 * H1; i++) drive1(1'b1, 1'(my1 % 2 == 0));
      repeat (2) drive1(1'b0, 1'b0);

      // Reset mid-frame while a pixel at (5,3) is being presented
      reset1(1'b0, 1'b0);
      while (!(mx1 == 5 && my1 == 3)) drive1(1'b1, 1'(my1 % 2 == 0));
      reset1(1'b1, 1'b1);
      for (int i = 0; i < 3 * W1; i++) drive1(1'b1, 1'(my1 % 2 == 0));
      repeat (3) drive1(1'b0, 1'b0);
      check_val("fend_count", fend_cnt, exp_fend);

      // Full-size instance: single 1 at (100,10) travels down the taps
      for (int i = 0; i < 15 * W2; i++) drive2(1'b1, 1'(mx2 == 100 && my2 == 10));
      repeat (3) drive2(1'b0, 1'b0);

      check_val("drain1", exp_q1.size(), 0);
      check_val("drain2", exp_q2.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/brief_line_window.md
Name: brief_line_window

Overview:
- Receiving end of the 1-bit line-delay path in the ORB/BRIEF datapath.
- Accepts a raster stream of binary pixels, one per enabled cycle.
- Outputs a vertical column of Pra_Rows bits per pixel: the current row plus the same column from the previous Pra_Rows-1 rows, with raster coordinates.
- Downstream BRIEF window/test logic consumes this column directly. Explicit address counters replace fixed-offset shift RAMs, so the line length is exact at any resolution.

Parameters:
- Pra_Width, 1920, active pixels per line; address counter wraps here.
- Pra_Height, 1080, lines per frame; row counter wraps here.
- Pra_Rows, 5, output column height (2..8); Pra_Rows-1 line memories are instantiated.

Ports:
- i_clk  input  1  system clock; all logic on rising edge
- i_rst  input  1  synchronous reset, active-high
- i_en  input  1  pixel strobe; i_data is valid this cycle
- i_data  input  1  binary pixel, raster order
- o_valid  output  1  o_col / o_x / o_y valid this cycle
- o_col  output  Pra_Rows  bit k = pixel k lines above the current one, same column (bit 0 = current)
- o_x  output  11  column of the output pixel
- o_y  output  11  row of the output pixel
- o_window_ok  output  1  high when all Pra_Rows taps hold real data (o_y >= Pra_Rows-1)
- o_frame_end  output  1  one-cycle pulse, aligned with the output for the last pixel of the frame

Behaviour:
- Reset is synchronous and active-high; i_clk is the only clock.
- Reset values: o_valid=0, o_col=0, o_x=0, o_y=0, o_window_ok=0, o_frame_end=0.
  - Column counter x=0, row counter y=0.
  - Line memory contents are not cleared.
- Counters advance only when i_en=1.
  - x: 0..Pra_Width-1, then wraps to 0 and y increments.
  - y: 0..Pra_Height-1, then wraps to 0.
- Line memories: Pra_Rows-1 RAMs, 1 bit x Pra_Width, all addressed by x.
  - Read-before-write on the same address in the same cycle.
  - RAM k writes the bit read from RAM k-1 (RAM 0 writes i_data), forming a cascade.
- Latency: exactly 1 cycle from the i_en cycle to o_valid. i_data, x and y are registered to align with the RAM read data.
- o_col[0] = registered i_data. o_col[k] = RAM k-1 read data, forced to 0 when y < k (masks stale memory after reset or at frame start).
- o_window_ok = o_valid & (o_y >= Pra_Rows-1).
- o_frame_end = 1 in the output cycle for x=Pra_Width-1, y=Pra_Height-1.
- i_en=0:
  - Counters and memories hold; o_valid=0; o_frame_end=0.
  - o_col, o_x, o_y hold their last values.
- Gapped strobes (any i_en duty cycle) give identical o_col sequences to a continuous stream.
- Reset mid-frame:
  - Counters restart at (0,0); any in-flight output is dropped (o_valid=0 next cycle).
  - Masking ensures no stale bits appear in o_col.
- Reset has priority over i_en in the same cycle.
- The counter width of 11 bits supports up to 2047; Pra_Width and Pra_Height must not exceed this.

Test Plan:
(Pra_Width=8, Pra_Height=6, Pra_Rows=3 unless stated.)
- Continuous stream, pixel = (x+y)&1:
  - Each o_col[k] = ((x+y-k)&1) when y>=k, else 0.
  - o_valid one cycle after each i_en.
  - o_window_ok first high at (0,2).
- Row-tagged stream, rows alternating all-1 / all-0 over 2 frames:
  - At frame 2 (0,0), o_col=3'b001 (row 0 all-1, older taps masked).
  - At (x,4), o_col=3'b101.
  - No frame-1 data leaks into frame-2 rows 0..1.
- Frame boundary:
  - o_frame_end pulses once per frame at output (7,5).
  - o_x/o_y wrap to (0,0) on the next pixel.
- Random i_en gaps (~40% duty), same pixel data as continuous:
  - o_col/o_x/o_y sequence on o_valid cycles identical to the continuous run.
- Reset asserted at (5,3) with i_en=1:
  - Next cycle all outputs 0.
  - First post-reset pixel yields o_x=0, o_y=0, o_col[2:1]=0.
- Pra_Width=1920, Pra_Height=1080, Pra_Rows=5, single 1 injected at (100,10):
  - Appears in o_col[k] at (100,10+k) for k=0..4.
  - All other taps stay 0.
